// File: rtl/serial_addern.sv
// -----------------------------------------------------------------------------
// serial_addern
//
// Multi-cycle N-bit adder/subtractor that consumes its operands D bits per
// clock, least-significant digit first. Operands, mode and carry-in are
// captured when Start is accepted. The digits are then processed over
// M = N/D cycles. The result is published in a single update at the end of
// the operation.
//
// Parameters
//   N : operand/result width (N >= 2)
//   D : digit width per cycle (must divide N); M = N/D digits per operation
//
// Ports
//   Clock    : rising-edge clock
//   Resetn   : asynchronous active-low reset
//   Start    : operation request, honoured whenever the block is not Busy
//   Sub      : 0 = A + B + Cin, 1 = A - B - Cin
//   Cin      : carry-in (add) / borrow-in (subtract)
//   A, B     : operands
//   S        : result register, updated only at the completion edge
//   Cout     : raw carry out of bit N-1 (in subtract mode, 1 = no borrow)
//   Overflow : two's-complement overflow of the operation
//   Busy     : high while digits are being processed
//   Done     : one-cycle pulse after S/Cout/Overflow have been updated
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module serial_addern #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic         Sub,
  input  logic         Cin,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Overflow,
  output logic         Busy,
  output logic         Done
);

  localparam int M  = N / D;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Working registers: operand shifters, partial result, carry, sign bits
  logic [N-1:0]  ra, rb, rs;
  logic          c;
  logic          sign_a, sign_bx;
  logic [CW-1:0] cnt;

  // Combinational helpers
  logic          accept;      // Start honoured this edge
  logic          last_digit;  // this RUN edge processes digit M-1
  logic [N-1:0]  bx;          // effective second operand
  logic          c0;          // effective initial carry
  logic [D:0]    digit_sum;   // {carry-out, digit} of the current digit
  logic [N-1:0]  digit_top;   // current digit placed in the top D bits
  logic [N-1:0]  rs_nxt;      // partial result after this digit
  logic          ovf_nxt;

  // Subtraction is A + ~B + 1 - Cin, so both B and the carry are inverted.
  assign bx = Sub ? ~B : B;
  assign c0 = Sub ? ~Cin : Cin;

  assign accept     = (state != RUN) && Start;
  assign last_digit = (cnt == CW'(M - 1));

  assign digit_sum = {1'b0, ra[D-1:0]} + {1'b0, rb[D-1:0]} + {{D{1'b0}}, c};

  // Result digits enter at the top and move down. After M digits the first
  // (least significant) one has reached bit 0.
  assign digit_top = N'(digit_sum[D-1:0]) << (N - D);
  assign rs_nxt    = (rs >> D) | digit_top;

  // Overflow only occurs when both effective operands share a sign and the
  // result sign differs from it.
  assign ovf_nxt = (sign_a == sign_bx) && (rs_nxt[N-1] != sign_a);

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered, so
    // no latch can be inferred for state_nxt.
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = Start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register and status flops
  // ---------------------------------------------------------------------------
  // Busy and Done are registered copies of the next state. They therefore
  // track the state exactly and do not glitch on state decoding.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks make every flop
      // sample pre-edge values, independent of statement order.
      state <= state_nxt;
      Busy  <= (state_nxt == RUN);
      Done  <= (state_nxt == DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, digit processing, result publication
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ra       <= '0;
      rb       <= '0;
      rs       <= '0;
      c        <= 1'b0;
      sign_a   <= 1'b0;
      sign_bx  <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept) begin
      ra      <= A;
      rb      <= bx;
      rs      <= '0;
      c       <= c0;
      sign_a  <= A[N-1];
      sign_bx <= bx[N-1];
      cnt     <= '0;
    end else if (state == RUN) begin
      ra  <= ra >> D;
      rb  <= rb >> D;
      rs  <= rs_nxt;
      c   <= digit_sum[D];
      cnt <= cnt + CW'(1);
      // The public result changes only here. Intermediate shifting stays in rs.
      if (last_digit) begin
        S        <= rs_nxt;
        Cout     <= digit_sum[D];
        Overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_addern.sv
// -----------------------------------------------------------------------------
// tb_serial_addern
//
// Drives three serial_addern instances (N=8/D=1, N=8/D=4, N=16/D=4) with
// directed vectors. Each expected result is hand-computed and queued when its
// Start is issued. A monitor pops the queue whenever an instance pulses Done
// and compares result, flags, latency and Busy duration. Between completions
// the monitor also checks that S/Cout/Overflow hold their values.
// -----------------------------------------------------------------------------
module tb_serial_addern;

  typedef struct {
    int          dut;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  logic clk, rst_n;
  int   cyc;
  int   checks, errors;
  exp_t sb[$];

  // Instance 0: N=8, D=1
  logic       start0, sub0, cin0, cout0, ovf0, busy0, done0;
  logic [7:0] a0, b0, s0;
  // Instance 1: N=8, D=4
  logic       start1, sub1, cin1, cout1, ovf1, busy1, done1;
  logic [7:0] a1, b1, s1;
  // Instance 2: N=16, D=4
  logic        start2, sub2, cin2, cout2, ovf2, busy2, done2;
  logic [15:0] a2, b2, s2;

  serial_addern #(.N(8), .D(1)) u_dut0 (
    .Clock(clk), .Resetn(rst_n), .Start(start0), .Sub(sub0), .Cin(cin0),
    .A(a0), .B(b0), .S(s0), .Cout(cout0), .Overflow(ovf0), .Busy(busy0), .Done(done0)
  );
  serial_addern #(.N(8), .D(4)) u_dut1 (
    .Clock(clk), .Resetn(rst_n), .Start(start1), .Sub(sub1), .Cin(cin1),
    .A(a1), .B(b1), .S(s1), .Cout(cout1), .Overflow(ovf1), .Busy(busy1), .Done(done1)
  );
  serial_addern #(.N(16), .D(4)) u_dut2 (
    .Clock(clk), .Resetn(rst_n), .Start(start2), .Sub(sub2), .Cin(cin2),
    .A(a2), .B(b2), .S(s2), .Cout(cout2), .Overflow(ovf2), .Busy(busy2), .Done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts rising edges. Read only on falling edges.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic int m_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic set_in(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, input logic start);
    case (k)
      0: begin a0 = a[7:0]; b0 = b[7:0]; sub0 = sub; cin0 = cin; start0 = start; end
      1: begin a1 = a[7:0]; b1 = b[7:0]; sub1 = sub; cin1 = cin; start1 = start; end
      default: begin a2 = a; b2 = b; sub2 = sub; cin2 = cin; start2 = start; end
    endcase
  endtask

  // Issues one Start pulse and queues the hand-computed response.
  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin,
                       input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    set_in(k, a, b, sub, cin, 1'b1);
    e.dut = k; e.s = es; e.cout = ec; e.ovf = eo; e.done_cyc = cyc + 1 + m_of(k);
    sb.push_back(e);
    @(negedge clk);
    set_in(k, a, b, sub, cin, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    int          busy_cnt [3];
    logic [15:0] last_s   [3];
    logic        last_c   [3];
    logic        last_o   [3];
    logic        prev_done[3];
    logic [15:0] cs;
    logic        cc, co, cb, cd;
    int          idx;
    for (int k = 0; k < 3; k++) begin
      busy_cnt[k] = 0; last_s[k] = '0; last_c[k] = 1'b0; last_o[k] = 1'b0; prev_done[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          busy_cnt[k] = 0; last_s[k] = '0; last_c[k] = 1'b0; last_o[k] = 1'b0; prev_done[k] = 1'b0;
          continue;
        end
        case (k)
          0: begin cs = {8'h00, s0}; cc = cout0; co = ovf0; cb = busy0; cd = done0; end
          1: begin cs = {8'h00, s1}; cc = cout1; co = ovf1; cb = busy1; cd = done1; end
          default: begin cs = s2; cc = cout2; co = ovf2; cb = busy2; cd = done2; end
        endcase
        if (cb) busy_cnt[k]++;
        if (cd) begin
          check($sformatf("dut%0d done_single_cycle", k), prev_done[k], 0);
          check($sformatf("dut%0d busy_with_done", k), cb, 0);
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].dut == k) idx = i;
          if (idx < 0) begin
            check($sformatf("dut%0d unexpected_done", k), cd, 0);
          end else begin
            check($sformatf("dut%0d S", k), cs, sb[idx].s);
            check($sformatf("dut%0d Cout", k), cc, sb[idx].cout);
            check($sformatf("dut%0d Overflow", k), co, sb[idx].ovf);
            check($sformatf("dut%0d done_cycle", k), cyc, sb[idx].done_cyc);
            check($sformatf("dut%0d busy_cycles", k), busy_cnt[k], m_of(k));
            sb.delete(idx);
          end
          busy_cnt[k] = 0;
          last_s[k] = cs; last_c[k] = cc; last_o[k] = co;
        end else begin
          check($sformatf("dut%0d S_hold", k), cs, last_s[k]);
          check($sformatf("dut%0d Cout_hold", k), cc, last_c[k]);
          check($sformatf("dut%0d Overflow_hold", k), co, last_o[k]);
        end
        prev_done[k] = cd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    int   k0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 3; k++) set_in(k, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    check("reset S0", s0, 0);
    check("reset flags0", {cout0, ovf0, busy0, done0}, 0);
    check("reset S2", s2, 0);
    check("reset flags2", {cout2, ovf2, busy2, done2}, 0);
    #2 rst_n = 1'b1;

    // N=8, D=1: add, wrap, carry-in, subtract
    issue(0, 16'h5A, 16'h33, 1'b0, 1'b0, 16'h8D, 1'b0, 1'b1); drain();
    issue(0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0); drain();
    issue(0, 16'h7F, 16'h00, 1'b0, 1'b1, 16'h80, 1'b0, 1'b1); drain();
    issue(0, 16'h10, 16'h01, 1'b1, 1'b0, 16'h0F, 1'b1, 1'b0); drain();
    issue(0, 16'h80, 16'h01, 1'b1, 1'b0, 16'h7F, 1'b1, 1'b1); drain();
    issue(0, 16'h00, 16'h01, 1'b1, 1'b0, 16'hFF, 1'b0, 1'b0); drain();
    issue(0, 16'h10, 16'h01, 1'b1, 1'b1, 16'h0E, 1'b1, 1'b0); drain();

    // Digit-serial widths
    issue(1, 16'h5A, 16'h33, 1'b0, 1'b0, 16'h8D, 1'b0, 1'b1); drain();
    issue(1, 16'h80, 16'h01, 1'b1, 1'b0, 16'h7F, 1'b1, 1'b1); drain();
    issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
    issue(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); drain();
    issue(2, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0); drain();

    // Start and operand changes mid-RUN are ignored
    issue(0, 16'h01, 16'h01, 1'b0, 1'b0, 16'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    set_in(0, 16'hFF, 16'h01, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_in(0, 16'hFF, 16'h01, 1'b1, 1'b1, 1'b0);
    drain();

    // Start held high through DONE: back-to-back operations M+1 cycles apart
    @(negedge clk);
    k0 = cyc;
    set_in(0, 16'h01, 16'h02, 1'b0, 1'b0, 1'b1);
    e.dut = 0; e.s = 16'h03; e.cout = 1'b0; e.ovf = 1'b0; e.done_cyc = k0 + 1 + 8;
    sb.push_back(e);
    e.s = 16'h07; e.done_cyc = k0 + 1 + 9 + 8;
    sb.push_back(e);
    @(negedge clk);
    set_in(0, 16'h03, 16'h04, 1'b0, 1'b0, 1'b1);
    while (cyc < k0 + 10) @(negedge clk);
    set_in(0, 16'h03, 16'h04, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset mid-operation after a completed 0x8D result
    issue(0, 16'h5A, 16'h33, 1'b0, 1'b0, 16'h8D, 1'b0, 1'b1); drain();
    @(negedge clk);
    set_in(0, 16'h5A, 16'h33, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(0, 16'h5A, 16'h33, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset busy", busy0, 1);
    check("pre_reset S", s0, 8'h8D);
    rst_n = 1'b0;
    #1;
    check("async_reset S", s0, 0);
    check("async_reset Cout", cout0, 0);
    check("async_reset Overflow", ovf0, 0);
    check("async_reset Busy", busy0, 0);
    check("async_reset Done", done0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(0, 16'h01, 16'h02, 1'b0, 1'b0, 16'h03, 1'b0, 1'b0); drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
